booth_mul: RTL and testbench

BOOTH_MUL -- requirements
Module: booth_mul

---
 rtl/booth_mul_pkg.sv | 5 +
 rtl/booth_mul_step.sv | 23 ++
 rtl/booth_mul.sv | 87 ++++++++
 tb/tb_booth_mul.sv | 132 +++++++++++++
 4 files changed

// File: rtl/booth_mul_pkg.sv
// booth_mul_pkg: shared FSM state encoding and default operand width for booth_mul
package booth_mul_pkg;
  localparam int N_DEF = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/booth_mul_step.sv
// booth_step: one radix-2 Booth iteration on {A,Q,Q-1}
//   a/q/q1 : current accumulator (N+1 bits), multiplier register, Q-1 bit
//   m      : sign-extended multiplicand (N+1 bits)
//   a_o/q_o/q1_o : state after the add/subtract and the arithmetic right shift
module booth_step #(
  parameter int N = 4
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic         q1,
  input  logic [N:0]   m,
  output logic [N:0]   a_o,
  output logic [N-1:0] q_o,
  output logic         q1_o
);
  logic [N:0] sum;
  always_comb begin
    sum  = (q[0] & ~q1) ? a - m : (~q[0] & q1) ? a + m : a;
    a_o  = {sum[N], sum[N:1]};
    q_o  = {sum[0], q[N-1:1]};
    q1_o = q[0];
  end
endmodule

// File: rtl/booth_mul.sv
// booth_mul: sequential signed N x N radix-2 Booth multiplier
//   clk, rst (async, active-high), start : launches an operation from IDLE
//   x, y  : signed multiplicand / multiplier, sampled at the start edge
//   z     : registered signed 2N-bit product, held until the next result
//   valid : one-cycle strobe when z is written
module booth_mul
  import booth_mul_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [N-1:0]   x,
  input  logic signed [N-1:0]   y,
  output logic signed [2*N-1:0] z,
  output logic                  valid
);
  localparam int CW = $clog2(N + 1);
  state_t         state_q, state_d;
  logic [N:0]     m_q, m_d, a_q, a_d, a_s;
  logic [N-1:0]   q_q, q_d, q_s;
  logic           q1_q, q1_d, q1_s;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] z_q, z_d;
  logic           valid_q, valid_d;
  booth_step #(.N(N)) u_step (
    .a(a_q), .q(q_q), .q1(q1_q), .m(m_q),
    .a_o(a_s), .q_o(q_s), .q1_o(q1_s)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      z_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      valid_q <= valid_d;
    end
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        m_d     = {x[N-1], x};
        q_d     = y;
        a_d     = '0;
        q1_d    = 1'b0;
        cnt_d   = CW'(N);
        state_d = CALC;
      end
      CALC: begin
        a_d   = a_s;
        q_d   = q_s;
        q1_d  = q1_s;
        cnt_d = cnt_q - CW'(1);
        // the step completing now is the last one: publish the shifted {A,Q}
        if (cnt_q == CW'(1)) begin
          z_d     = {a_s[N-1:0], q_s};
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign z     = z_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_booth_mul.sv
// tb_booth_mul: directed self-checking bench for booth_mul (N=4)
module tb_booth_mul;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic signed [3:0] x = '0;
  logic signed [3:0] y = '0;
  logic signed [7:0] z;
  logic              valid;
  int n_vec = 0;
  int n_err = 0;

  booth_mul #(.N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .z(z), .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] xi, input logic [3:0] yi);
    @(negedge clk);
    x = xi;
    y = yi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int c0, input logic [7:0] ez);
    int c = c0;
    while (valid !== 1'b1 && c < 30) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, c, 4);
    check({tag, "_z"}, {24'd0, z}, {24'd0, ez});
    @(negedge clk);
    check({tag, "_vlow"}, {31'd0, valid}, 0);
    check({tag, "_hold"}, {24'd0, z}, {24'd0, ez});
  endtask

  task automatic count_valid(input string tag, input int cycles);
    int k = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (valid === 1'b1) k++;
    end
    check(tag, k, 0);
  endtask

  initial begin
    int p;
    int t0;
    int t1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_z", {24'd0, z}, 0);
    check("rst_valid", {31'd0, valid}, 0);
    rst = 1'b0;
    start = 1'b0;
    count_valid("rst_start_ignored", 8);

    pulse(4'd3, 4'd6);
    wait_valid("p3x6", 0, 8'd18);
    repeat (5) @(negedge clk);
    check("p3x6_hold_long", {24'd0, z}, 32'd18);

    pulse(-4'sd3, 4'd6);  wait_valid("m3x6", 0, 8'hEE);
    pulse(-4'sd8, 4'd7);  wait_valid("m8x7", 0, 8'hC8);
    pulse(-4'sd8, -4'sd8); wait_valid("m8xm8", 0, 8'h40);
    pulse(4'd7, 4'd7);    wait_valid("p7x7", 0, 8'd49);
    pulse(4'd0, -4'sd5);  wait_valid("z0xm5", 0, 8'h00);
    pulse(-4'sd1, -4'sd1); wait_valid("m1xm1", 0, 8'h01);

    pulse(4'd5, 4'd3);
    @(negedge clk);
    x = 4'd2;
    y = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("ignore", 2, 8'd15);
    count_valid("ignore_noextra", 8);

    pulse(4'd5, 4'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_z", {24'd0, z}, 0);
    check("abort_valid", {31'd0, valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    count_valid("abort_novalid", 8);
    pulse(4'd5, 4'd3);
    wait_valid("after_abort", 0, 8'd15);

    @(negedge clk);
    x = 4'd3;
    y = 4'd2;
    start = 1'b1;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 40 && t1 < 0; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        if (t0 < 0) t0 = i;
        else t1 = i;
      end
    end
    start = 1'b0;
    check("cont_period", t1 - t0, 6);
    check("cont_z", {24'd0, z}, 32'd6);
    repeat (8) @(negedge clk);

    for (int xi = -8; xi < 8; xi++)
      for (int yi = -8; yi < 8; yi++) begin
        p = xi * yi;
        pulse(xi[3:0], yi[3:0]);
        wait_valid($sformatf("sweep_%0d_%0d", xi, yi), 0, p[7:0]);
      end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
